// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
//   Pipelined main control for the five-stage processor. Decodes the ID opcode,
//   stages the control bits through ID/EX, EX/MEM and MEM/WB, detects load-use
//   hazards (one bubble), resolves BEQ in EX, redirects the PC for J in ID and
//   flags undefined opcodes.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   id_valid, id_op      ID instruction present / its opcode
//   id_rs, id_rt         ID source register fields
//   ex_zero              ALU zero flag of the EX instruction
//   stall, flush, pc_sel combinational hazard / redirect controls
//                        (pc_sel: 0 PC+4, 1 branch target, 2 jump target)
//   ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal   EX-stage controls
//   mem_read, mem_write                             MEM-stage controls
//   wb_mem_to_reg, wb_reg_write                     WB-stage controls
//                        (wb_mem_to_reg=1 selects the ALU result)
// -----------------------------------------------------------------------------
module pipe_ctrl_unit #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int REG_AW  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [OP_W-1:0]    id_op,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic               ex_zero,
   output logic               stall,
   output logic               flush,
   output logic [1:0]         pc_sel,
   output logic               ex_reg_dst,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_illegal,
   output logic               mem_read,
   output logic               mem_write,
   output logic               wb_mem_to_reg,
   output logic               wb_reg_write
);

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = OP_W'(0),
      OP_RTYPE = OP_W'(20),
      OP_BEQ   = OP_W'(25),
      OP_J     = OP_W'(26),
      OP_ADDI  = OP_W'(39),
      OP_SUBI  = OP_W'(40),
      OP_SW    = OP_W'(41),
      OP_LW    = OP_W'(42)
   } op_e;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD   = ALUOP_W'(0),
      ALU_SUB   = ALUOP_W'(1),
      ALU_FUNCT = ALUOP_W'(2)
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_sel_e;

   // ---------------------------------------------------------------- decode
   logic               dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
   logic               dec_mem_to_reg, dec_reg_write, dec_is_beq, dec_illegal;
   logic [ALUOP_W-1:0] dec_alu_op;

   always_comb begin
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_alu_op     = ALU_ADD;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_reg_write  = 1'b0;
      dec_is_beq     = 1'b0;
      dec_illegal    = 1'b0;
      if (id_valid) begin
         case (id_op)
            OP_NOP, OP_J: ;
            OP_RTYPE: begin
               dec_reg_dst    = 1'b1;
               dec_alu_op     = ALU_FUNCT;
               dec_mem_to_reg = 1'b1;
               dec_reg_write  = 1'b1;
            end
            OP_ADDI: begin
               dec_alu_src    = 1'b1;
               dec_mem_to_reg = 1'b1;
               dec_reg_write  = 1'b1;
            end
            OP_SUBI: begin
               dec_alu_src    = 1'b1;
               dec_alu_op     = ALU_SUB;
               dec_mem_to_reg = 1'b1;
               dec_reg_write  = 1'b1;
            end
            OP_SW: begin
               dec_alu_src   = 1'b1;
               dec_mem_write = 1'b1;
            end
            OP_LW: begin
               dec_alu_src   = 1'b1;
               dec_mem_read  = 1'b1;
               dec_reg_write = 1'b1;
            end
            OP_BEQ: begin
               dec_alu_op = ALU_SUB;
               dec_is_beq = 1'b1;
            end
            default: dec_illegal = 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------- EX-only state
   logic              ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
   logic              ex_is_beq;
   logic [REG_AW-1:0] ex_rt;
   logic              mem_mem_to_reg, mem_reg_write;

   // ------------------------------------------------ hazards and redirect
   logic taken, load_use, jump;

   assign taken    = ex_is_beq & ex_zero;
   // Register 0 is hard-wired, so a load into it never creates a dependency.
   assign load_use = ex_mem_read & id_valid & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));
   assign jump     = id_valid & (id_op == OP_J);

   always_comb begin
      stall  = 1'b0;
      flush  = 1'b0;
      pc_sel = PC_SEQ;
      if (taken) begin
         flush  = 1'b1;
         pc_sel = PC_BRANCH;
      end else if (load_use) begin
         stall = 1'b1;
      end else if (jump) begin
         flush  = 1'b1;
         pc_sel = PC_JUMP;
      end
   end

   // ------------------------------------------------------ stage registers
   // The ID instruction is killed on a taken branch and held on a stall;
   // either way EX takes a bubble. A J decodes to all-zero controls already.
   logic bubble;
   assign bubble = taken | load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg_dst     <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_alu_op      <= '0;
         ex_illegal     <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_is_beq      <= 1'b0;
         ex_rt          <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_reg_write  <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_reg_write   <= 1'b0;
      end else begin
         if (bubble) begin
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            ex_illegal    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_beq     <= 1'b0;
            ex_rt         <= '0;
         end else begin
            ex_reg_dst    <= dec_reg_dst;
            ex_alu_src    <= dec_alu_src;
            ex_alu_op     <= dec_alu_op;
            ex_illegal    <= dec_illegal;
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_mem_to_reg <= dec_mem_to_reg;
            ex_reg_write  <= dec_reg_write;
            ex_is_beq     <= dec_is_beq;
            ex_rt         <= id_valid ? id_rt : '0;
         end
         mem_read       <= ex_mem_read;
         mem_write      <= ex_mem_write;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_reg_write  <= ex_reg_write;
         wb_mem_to_reg  <= mem_mem_to_reg;
         wb_reg_write   <= mem_reg_write;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//   Directed-vector bench for pipe_ctrl_unit. Inputs change 1 ns after each
//   rising edge; outputs are sampled a further 1 ns later, well clear of the
//   next edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

   localparam int OP_W    = 6;
   localparam int ALUOP_W = 3;
   localparam int REG_AW  = 5;

   localparam logic [OP_W-1:0] NOP = 6'd0,  RT  = 6'd20, BEQ = 6'd25, JMP = 6'd26,
                               ADDI = 6'd39, SUBI = 6'd40, SW = 6'd41, LW = 6'd42,
                               BAD = 6'd63;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               id_valid;
   logic [OP_W-1:0]    id_op;
   logic [REG_AW-1:0]  id_rs, id_rt;
   logic               ex_zero;
   logic               stall, flush;
   logic [1:0]         pc_sel;
   logic               ex_reg_dst, ex_alu_src, ex_illegal;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               mem_read, mem_write, wb_mem_to_reg, wb_reg_write;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   pipe_ctrl_unit #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
      .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
      .stall(stall), .flush(flush), .pc_sel(pc_sel),
      .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .ex_illegal(ex_illegal), .mem_read(mem_read), .mem_write(mem_write),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Present an ID instruction, then let the combinational outputs settle.
   task automatic drive(input logic v, input logic [OP_W-1:0] op,
                        input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic z);
      id_valid = v; id_op = op; id_rs = rs; id_rt = rt; ex_zero = z;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Packed view of the EX controls: {reg_dst, alu_src, alu_op, illegal}
   function automatic logic [31:0] ex_vec;
      return {26'd0, ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal};
   endfunction

   initial begin
      rst_n = 1'b0;
      drive(1'b0, NOP, 0, 0, 1'b0);
      tick; tick;
      check("rst_ex",    ex_vec(), 0);
      check("rst_mem",   {mem_read, mem_write}, 0);
      check("rst_wb",    {wb_mem_to_reg, wb_reg_write}, 0);
      check("rst_haz",   {stall, flush, pc_sel}, 0);
      rst_n = 1'b1;

      // Latency: LW in ID at cycle 1
      drive(1'b1, LW, 5'd1, 5'd2, 1'b0);
      check("lw_id_nostall", stall, 0);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);
      check("lw_ex", ex_vec(), 32'b0_1_000_0);
      tick;
      check("lw_mem", {mem_read, mem_write}, 2'b10);
      tick;
      check("lw_wb", {wb_reg_write, wb_mem_to_reg}, 2'b10);
      check("lw_mem_gone", mem_read, 0);

      // R-type, SUBI and SW decode
      drive(1'b1, RT, 5'd1, 5'd2, 1'b0);
      tick; drive(1'b1, SUBI, 5'd3, 5'd4, 1'b0);
      check("rtype_ex", ex_vec(), 32'b1_0_010_0);
      tick; drive(1'b1, SW, 5'd3, 5'd4, 1'b0);
      check("subi_ex", ex_vec(), 32'b0_1_001_0);
      check("rtype_mem", {mem_read, mem_write}, 0);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);
      check("rtype_wb", {wb_reg_write, wb_mem_to_reg}, 2'b11);
      tick;
      check("sw_mem", {mem_read, mem_write}, 2'b01);
      tick;
      check("sw_wb", {wb_reg_write, wb_mem_to_reg}, 0);

      // Load-use: LW rt=5 then ADDI rs=5
      drive(1'b1, LW, 5'd0, 5'd5, 1'b0);
      tick; drive(1'b1, ADDI, 5'd5, 5'd7, 1'b0);
      check("lu_stall", {stall, flush, pc_sel}, 4'b1000);
      tick;
      check("lu_bubble", ex_vec(), 0);
      check("lu_release", stall, 0);
      check("lu_lw_mem", mem_read, 1);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);
      check("lu_addi_ex", ex_vec(), 32'b0_1_000_0);

      // Load-use negatives
      drive(1'b1, LW, 5'd0, 5'd0, 1'b0);
      tick; drive(1'b1, ADDI, 5'd0, 5'd0, 1'b0);
      check("lu_r0", stall, 0);
      drive(1'b1, LW, 5'd0, 5'd3, 1'b0);
      tick; drive(1'b1, RT, 5'd1, 5'd2, 1'b0);
      check("lu_indep", stall, 0);
      drive(1'b1, RT, 5'd3, 5'd3, 1'b0);
      check("lu_rt_match", stall, 1);
      drive(1'b0, RT, 5'd3, 5'd3, 1'b0);
      check("lu_invalid", stall, 0);
      tick;

      // Taken branch
      drive(1'b1, BEQ, 5'd1, 5'd2, 1'b0);
      tick; drive(1'b1, ADDI, 5'd1, 5'd2, 1'b1);
      check("beq_ex", ex_vec(), 32'b0_0_001_0);
      check("beq_taken", {stall, flush, pc_sel}, 4'b0101);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);
      check("beq_killed", ex_vec(), 0);
      check("beq_mem", {mem_read, mem_write}, 0);
      // Branch beats a J waiting in ID
      drive(1'b1, BEQ, 0, 0, 1'b0);
      tick; drive(1'b1, JMP, 0, 0, 1'b1);
      check("beq_over_j", {stall, flush, pc_sel}, 4'b0101);
      // Not taken
      drive(1'b1, NOP, 0, 0, 1'b0);
      check("beq_not_taken", {stall, flush, pc_sel}, 0);
      tick;

      // Jump
      drive(1'b1, JMP, 5'd9, 5'd9, 1'b0);
      check("j_redirect", {stall, flush, pc_sel}, 4'b0110);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);
      check("j_ex_nop", ex_vec(), 0);

      // Jump behind a load-use stall
      drive(1'b1, LW, 5'd0, 5'd4, 1'b0);
      tick; drive(1'b1, JMP, 5'd4, 5'd0, 1'b0);
      check("j_stalled", {stall, flush, pc_sel}, 4'b1000);
      tick;
      check("j_after_stall", {stall, flush, pc_sel}, 4'b0110);
      tick; drive(1'b0, NOP, 0, 0, 1'b0);

      // Illegal opcode
      drive(1'b1, BAD, 0, 0, 1'b0);
      tick; drive(1'b0, BAD, 0, 0, 1'b0);
      check("ill_ex", ex_vec(), 32'b0_0_000_1);
      tick;
      check("ill_invalid_ex", ex_vec(), 0);
      check("ill_mem", {mem_read, mem_write}, 0);
      tick;
      check("ill_wb", {wb_reg_write, wb_mem_to_reg}, 0);

      // Reset mid-stream with LW in MEM
      drive(1'b1, LW, 5'd0, 5'd6, 1'b0);
      tick; drive(1'b1, ADDI, 5'd6, 5'd1, 1'b0);
      tick;
      check("rst2_pre", mem_read, 1);
      rst_n = 1'b0;
      #1;
      check("rst2_mem", {mem_read, mem_write}, 0);
      check("rst2_ex", ex_vec(), 0);
      check("rst2_wb", {wb_mem_to_reg, wb_reg_write}, 0);
      drive(1'b0, NOP, 0, 0, 1'b0);
      check("rst2_haz", {stall, flush, pc_sel}, 0);
      tick;
      rst_n = 1'b1;
      tick;
      check("rst2_post1", mem_read, 0);
      tick;
      check("rst2_post2", mem_read, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
